// File: rtl/image_feeder.sv
// image_feeder: host-side front end of the train/test/classify engine.
// Accepts one label/mode descriptor per image, packs 8-bit pixels four to a
// 32-bit word, streams the image to the classifier under its ready, then
// waits for valid_all and returns the classifier's label with a running count.
// Optional build macro: FEEDER_TIMEOUT_EN adds a WAIT_DONE watchdog that
// aborts the image after TIMEOUT cycles and pulses timeout_err.
module image_feeder #(
  parameter int IM_WID   = 28,
  parameter int IM_HEI   = 28,
  parameter int PIX_W    = 8,
  parameter int WORD_PIX = 4,
  parameter int TIMEOUT  = 65535
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             desc_valid,
  input  logic [7:0]       desc_label,
  input  logic [1:0]       desc_mode,
  output logic             desc_ready,
  input  logic             pix_valid,
  input  logic [PIX_W-1:0] pix_in,
  output logic             pix_ready,
  output logic             start_main,
  output logic [1:0]       train_test_classify,
  output logic [7:0]       test_label,
  output logic [31:0]      image_in,
  output logic             valid_image,
  input  logic             ready,
  input  logic             valid_all,
  input  logic [7:0]       image_label,
  output logic             result_valid,
  output logic [7:0]       result_label,
  output logic [15:0]      img_count,
  output logic             busy,
  output logic             timeout_err
);

  localparam int NPIX   = IM_WID * IM_HEI;
  localparam int NWORDS = NPIX / WORD_PIX;
  localparam int PCW    = $clog2(NPIX + 1);
  localparam int WCW    = $clog2(NWORDS + 1);
  localparam int LW     = (WORD_PIX > 1) ? $clog2(WORD_PIX) : 1;

  localparam logic [PCW-1:0] NPIX_C      = PCW'(NPIX);
  localparam logic [WCW-1:0] LAST_WORD_C = WCW'(NWORDS - 1);
  localparam logic [LW-1:0]  LAST_LANE_C = LW'(WORD_PIX - 1);

  // Reject parameter sets that cannot pack into a 32-bit word or a 16-bit watchdog.
  if (PIX_W * WORD_PIX != 32 || (NPIX % WORD_PIX) != 0 || TIMEOUT < 1 || TIMEOUT > 65535) begin : g_param_check
    $error("image_feeder: illegal parameter set");
  end

  typedef enum logic [2:0] {S_IDLE, S_START, S_STREAM, S_WAIT_DONE, S_REPORT} state_t;

  state_t         state_q, state_d;
  logic           desc_ready_q, desc_ready_d;
  logic           start_main_q, start_main_d;
  logic [1:0]     mode_q, mode_d;
  logic [7:0]     label_q, label_d;
  logic [31:0]    image_in_q, image_in_d;
  logic           valid_image_q, valid_image_d;
  logic           result_valid_q, result_valid_d;
  logic [7:0]     result_label_q, result_label_d;
  logic [15:0]    img_count_q, img_count_d;
  logic           busy_q, busy_d;
  logic [PCW-1:0] pix_cnt_q, pix_cnt_d;
  logic [WCW-1:0] word_cnt_q, word_cnt_d;
  logic [LW-1:0]  lane_q, lane_d;
  logic [31:0]    pack_q, pack_d;
`ifdef FEEDER_TIMEOUT_EN
  localparam logic [15:0] TO_C = 16'(TIMEOUT);
  logic [15:0]    to_cnt_q, to_cnt_d;
  logic           timeout_err_q, timeout_err_d;
`endif

  assign desc_ready          = desc_ready_q;
  assign start_main          = start_main_q;
  assign train_test_classify = mode_q;
  assign test_label          = label_q;
  assign image_in            = image_in_q;
  assign valid_image         = valid_image_q;
  assign result_valid        = result_valid_q;
  assign result_label        = result_label_q;
  assign img_count           = img_count_q;
  assign busy                = busy_q;
`ifdef FEEDER_TIMEOUT_EN
  assign timeout_err         = timeout_err_q;
`else
  assign timeout_err         = 1'b0;
`endif

  // Next-state, packing and handshake logic; pix_ready must follow ready combinationally.
  always_comb begin
    state_d        = state_q;
    desc_ready_d   = desc_ready_q;
    start_main_d   = 1'b0;
    mode_d         = mode_q;
    label_d        = label_q;
    image_in_d     = image_in_q;
    valid_image_d  = valid_image_q;
    result_valid_d = 1'b0;
    result_label_d = result_label_q;
    img_count_d    = img_count_q;
    busy_d         = busy_q;
    pix_cnt_d      = pix_cnt_q;
    word_cnt_d     = word_cnt_q;
    lane_d         = lane_q;
    pack_d         = pack_q;
    pix_ready      = 1'b0;
`ifdef FEEDER_TIMEOUT_EN
    to_cnt_d       = to_cnt_q;
    timeout_err_d  = 1'b0;
`endif
    case (state_q)
      S_IDLE: begin
        if (desc_valid && desc_ready_q) begin
          label_d      = desc_label;
          mode_d       = desc_mode;
          start_main_d = 1'b1;
          state_d      = S_START;
        end
      end
      S_START: begin
        pix_cnt_d  = '0;
        word_cnt_d = '0;
        lane_d     = '0;
`ifdef FEEDER_TIMEOUT_EN
        to_cnt_d   = '0;
`endif
        state_d    = S_STREAM;
      end
      S_STREAM: begin
        // A new pixel is taken only if the output word is free or leaving this cycle.
        pix_ready = (pix_cnt_q != NPIX_C) && (!valid_image_q || ready);
        if (valid_image_q && ready) begin
          valid_image_d = 1'b0;
          word_cnt_d    = word_cnt_q + WCW'(1);
          if (word_cnt_q == LAST_WORD_C) state_d = S_WAIT_DONE;
        end
        if (pix_valid && pix_ready) begin
          for (int p = 0; p < WORD_PIX; p++) begin
            if (lane_q == LW'(p)) pack_d[p*PIX_W +: PIX_W] = pix_in;
          end
          pix_cnt_d = pix_cnt_q + PCW'(1);
          if (lane_q == LAST_LANE_C) begin
            image_in_d    = pack_d;
            valid_image_d = 1'b1;
            lane_d        = '0;
          end else begin
            lane_d = lane_q + LW'(1);
          end
        end
      end
      S_WAIT_DONE: begin
        if (valid_all) begin
          result_label_d = image_label;
          result_valid_d = 1'b1;
          img_count_d    = img_count_q + 16'd1;
          state_d        = S_REPORT;
        end
`ifdef FEEDER_TIMEOUT_EN
        else if (to_cnt_q == TO_C - 16'd1) begin
          timeout_err_d = 1'b1;
          state_d       = S_IDLE;
        end else begin
          to_cnt_d = to_cnt_q + 16'd1;
        end
`endif
      end
      S_REPORT: state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
    desc_ready_d = (state_d == S_IDLE);
    busy_d       = (state_d != S_IDLE);
  end

  // State and registered outputs; reset aborts any image in flight.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q        <= S_IDLE;
      desc_ready_q   <= 1'b0;
      start_main_q   <= 1'b0;
      mode_q         <= '0;
      label_q        <= '0;
      image_in_q     <= '0;
      valid_image_q  <= 1'b0;
      result_valid_q <= 1'b0;
      result_label_q <= '0;
      img_count_q    <= '0;
      busy_q         <= 1'b0;
      pix_cnt_q      <= '0;
      word_cnt_q     <= '0;
      lane_q         <= '0;
      pack_q         <= '0;
`ifdef FEEDER_TIMEOUT_EN
      to_cnt_q       <= '0;
      timeout_err_q  <= 1'b0;
`endif
    end else begin
      state_q        <= state_d;
      desc_ready_q   <= desc_ready_d;
      start_main_q   <= start_main_d;
      mode_q         <= mode_d;
      label_q        <= label_d;
      image_in_q     <= image_in_d;
      valid_image_q  <= valid_image_d;
      result_valid_q <= result_valid_d;
      result_label_q <= result_label_d;
      img_count_q    <= img_count_d;
      busy_q         <= busy_d;
      pix_cnt_q      <= pix_cnt_d;
      word_cnt_q     <= word_cnt_d;
      lane_q         <= lane_d;
      pack_q         <= pack_d;
`ifdef FEEDER_TIMEOUT_EN
      to_cnt_q       <= to_cnt_d;
      timeout_err_q  <= timeout_err_d;
`endif
    end
  end

endmodule

// File: tb/tb_image_feeder.sv
// Bench for image_feeder: directed images with a pixel-to-word model and a
// per-cycle negedge monitor for handshakes, word contents and label stability.
module tb_image_feeder;
  localparam int NPIX   = 784;
  localparam int NWORDS = 196;

  logic        clk = 1'b0;
  logic        rst;
  logic        desc_valid;
  logic [7:0]  desc_label;
  logic [1:0]  desc_mode;
  logic        desc_ready;
  logic        pix_valid;
  logic [7:0]  pix_in;
  logic        pix_ready;
  logic        start_main;
  logic [1:0]  train_test_classify;
  logic [7:0]  test_label;
  logic [31:0] image_in;
  logic        valid_image;
  logic        ready;
  logic        valid_all;
  logic [7:0]  image_label;
  logic        result_valid;
  logic [7:0]  result_label;
  logic [15:0] img_count;
  logic        busy;
  logic        timeout_err;

  int vectors = 0;
  int miscompares = 0;
  int exp_img = 0;

  always #5 clk = ~clk;

  image_feeder #(
    .IM_WID(28), .IM_HEI(28), .PIX_W(8), .WORD_PIX(4), .TIMEOUT(100)
  ) dut (
    .clk(clk), .rst(rst),
    .desc_valid(desc_valid), .desc_label(desc_label), .desc_mode(desc_mode), .desc_ready(desc_ready),
    .pix_valid(pix_valid), .pix_in(pix_in), .pix_ready(pix_ready),
    .start_main(start_main), .train_test_classify(train_test_classify), .test_label(test_label),
    .image_in(image_in), .valid_image(valid_image), .ready(ready),
    .valid_all(valid_all), .image_label(image_label),
    .result_valid(result_valid), .result_label(result_label), .img_count(img_count),
    .busy(busy), .timeout_err(timeout_err)
  );

  // Pixel k of an image has value k mod 256; pixel 4w+p sits in byte p of word w.
  function automatic logic [31:0] exp_word(input int w);
    logic [31:0] r;
    for (int p = 0; p < 4; p++) r[p*8 +: 8] = 8'((4*w + p) % 256);
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor state
  int          xfer_cnt = 0;
  logic [31:0] first_word, word64, last_word, prev_word;
  time         last_xfer_time = 0;
  logic        prev_acc = 1'b0, stalled_prev = 1'b0;
  logic [7:0]  prev_lbl, cur_lbl;
  logic [1:0]  prev_mode, cur_mode;

  always @(negedge clk) begin
    if (!rst) begin
      xfer_cnt     = 0;
      prev_acc     = 1'b0;
      stalled_prev = 1'b0;
    end else begin
      chk("start_main_timing", start_main, prev_acc);
      if (prev_acc) begin
        cur_lbl  = prev_lbl;
        cur_mode = prev_mode;
        xfer_cnt = 0;
      end
      if (busy) begin
        chk("test_label_stable", test_label, cur_lbl);
        chk("mode_stable", train_test_classify, cur_mode);
      end else begin
        chk("pix_ready_idle", pix_ready, 1'b0);
      end
      if (stalled_prev) begin
        chk("hold_valid", valid_image, 1'b1);
        chk("hold_word", image_in, prev_word);
      end
      if (valid_image && !ready) chk("pix_ready_stall", pix_ready, 1'b0);
      if (valid_image && ready) begin
        if (xfer_cnt < NWORDS) chk("word_data", image_in, exp_word(xfer_cnt));
        else chk("word_overrun", xfer_cnt, NWORDS - 1);
        if (xfer_cnt == 0)  first_word = image_in;
        if (xfer_cnt == 64) word64 = image_in;
        last_word      = image_in;
        last_xfer_time = $time;
        xfer_cnt++;
      end
      stalled_prev = valid_image && !ready;
      prev_word    = image_in;
      prev_acc     = desc_valid && desc_ready;
      prev_lbl     = desc_label;
      prev_mode    = desc_mode;
    end
  end

  task automatic send_desc(input logic [7:0] l, input logic [1:0] m);
    int n = 0;
    logic acc = 1'b0;
    @(posedge clk); #1;
    desc_valid = 1'b1; desc_label = l; desc_mode = m;
    while (!acc && n < 50) begin
      @(negedge clk); acc = desc_ready;
      @(posedge clk); #1; n++;
    end
    chk("desc_accept", acc, 1'b1);
    desc_valid = 1'b0;
    @(negedge clk);
    chk("start_after_accept", start_main, 1'b1);
    chk("busy_at_start", busy, 1'b1);
    chk("label_latched", test_label, l);
    chk("mode_latched", train_test_classify, m);
  endtask

  task automatic feed(input bit gaps, input int stop_words);
    int k = 0;
    int n = 0;
    logic acc;
    @(posedge clk); #1;
    while (k < NPIX && xfer_cnt < stop_words && n < 5000) begin
      if (!pix_valid) begin
        pix_valid = gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
        pix_in    = 8'(k % 256);
      end
      @(negedge clk); acc = pix_valid && pix_ready;
      @(posedge clk); #1;
      if (acc) begin k++; pix_valid = 1'b0; end
      n++;
    end
    pix_valid = 1'b0;
    chk("feed_budget", n < 5000, 1'b1);
  endtask

  task automatic drive_ready(input int stop_words);
    int n = 0;
    @(posedge clk); #1;
    while (xfer_cnt < stop_words && n < 5000) begin
      ready = (n % 3 == 0);
      @(posedge clk); #1; n++;
    end
    ready = 1'b1;
  endtask

  task automatic stream(input bit bp, input bit gaps, input int stop_words);
    int n = 0;
    fork
      feed(gaps, stop_words);
      begin if (bp) drive_ready(stop_words); end
    join
    while (xfer_cnt < stop_words && n < 200) begin @(posedge clk); #1; n++; end
    chk("stream_words_reached", xfer_cnt >= stop_words, 1'b1);
  endtask

  task automatic finish_image(input logic [7:0] l);
    int n = 0;
    logic got = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("wait_busy", busy, 1'b1);
      chk("no_early_result", result_valid, 1'b0);
      chk("no_pix_in_wait", pix_ready, 1'b0);
    end
    chk("xfer_total", xfer_cnt, NWORDS);
    chk("first_word", first_word, 32'h03020100);
    chk("word64", word64, 32'h03020100);
    chk("last_word", last_word, 32'h0F0E0D0C);
    @(posedge clk); #1;
    valid_all = 1'b1; image_label = l;
    while (!got && n < 10) begin @(negedge clk); got = result_valid; n++; end
    chk("result_seen", got, 1'b1);
    chk("result_latency", n, 2);
    chk("result_label", result_label, l);
    exp_img++;
    chk("img_count", img_count, exp_img);
    @(posedge clk); #1;
    valid_all = 1'b0; image_label = 8'h00;
    @(negedge clk);
    chk("result_one_cycle", result_valid, 1'b0);
    chk("idle_busy", busy, 1'b0);
    chk("idle_desc_ready", desc_ready, 1'b1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: simulation did not finish, limit 1000000 ns");
    $fatal(1);
  end

  initial begin
    logic got;
    logic stuck;
    int n;
    rst = 1'b0; desc_valid = 1'b0; desc_label = 8'h00; desc_mode = 2'b00;
    pix_valid = 1'b0; pix_in = 8'h00; ready = 1'b1; valid_all = 1'b0; image_label = 8'h00;

    // T1 reset
    repeat (3) @(negedge clk);
    chk("rst_outputs", {desc_ready, pix_ready, start_main, train_test_classify, test_label,
                        valid_image, result_valid, result_label, busy, timeout_err}, 32'h0);
    chk("rst_image_in", image_in, 32'h0);
    chk("rst_img_count", img_count, 32'h0);
    chk("rst_busy", busy, 1'b0);
    #2 rst = 1'b1;
    #1 chk("desc_ready_before_edge", desc_ready, 1'b0);
    @(negedge clk);
    chk("desc_ready_after_release", desc_ready, 1'b1);

    // T2 nominal image
    send_desc(8'd7, 2'd2);
    stream(1'b0, 1'b0, NWORDS);
    finish_image(8'd7);

    // T3 backpressure and gaps, T5 descriptor held while busy
    send_desc(8'd3, 2'd1);
    #1;
    desc_valid = 1'b1; desc_label = 8'h55; desc_mode = 2'd0;
    stream(1'b1, 1'b1, NWORDS);
    finish_image(8'd3);
    @(posedge clk); #1;
    desc_valid = 1'b0;
    @(negedge clk);
    chk("held_desc_start", start_main, 1'b1);
    chk("held_desc_label", test_label, 8'h55);
    chk("held_desc_mode", train_test_classify, 2'd0);

    // T4 reset mid-stream on the held image
    stream(1'b0, 1'b0, 100);
    #1 rst = 1'b0;
    #1;
    chk("midrst_outputs", {desc_ready, pix_ready, start_main, train_test_classify, test_label,
                           valid_image, result_valid, result_label, busy, timeout_err}, 32'h0);
    chk("midrst_image_in", image_in, 32'h0);
    chk("midrst_img_count", img_count, 32'h0);
    exp_img = 0;
    repeat (2) @(negedge clk);
    #2 rst = 1'b1;
    send_desc(8'h21, 2'd1);
    stream(1'b0, 1'b1, NWORDS);
    finish_image(8'h21);

    // T6 classifier never answers
    send_desc(8'h44, 2'd3);
    stream(1'b0, 1'b0, NWORDS);
`ifdef FEEDER_TIMEOUT_EN
    got = 1'b0; n = 0;
    while (!got && n < 300) begin @(negedge clk); got = timeout_err; n++; end
    chk("timeout_seen", got, 1'b1);
    chk("timeout_delay", 32'(($time - last_xfer_time) / 10), 101);
    chk("timeout_idle", busy, 1'b0);
    chk("timeout_no_result", result_valid, 1'b0);
    chk("timeout_img_count", img_count, exp_img);
    @(negedge clk);
    chk("timeout_one_cycle", timeout_err, 1'b0);
`else
    stuck = 1'b1;
    repeat (300) begin
      @(negedge clk);
      if (!busy || timeout_err || result_valid) stuck = 1'b0;
    end
    chk("wait_forever", stuck, 1'b1);
    chk("no_timeout_img_count", img_count, exp_img);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
